// File: rtl/axi_4_lite_mst_if.sv
// Command, response and AXI4-Lite master bus bundle for axi_4_lite_mst.
// The master modport is the engine's view; the slave modport is the opposite side.
interface axi_4_lite_mst_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Local command channel
  logic                     CMD_VALID;
  logic                     CMD_READY;
  logic                     CMD_WRITE;
  logic [ADDR_WIDTH-1:0]    CMD_ADDR;
  logic [DATA_WIDTH-1:0]    CMD_WDATA;
  logic [STRB_WIDTH-1:0]    CMD_WSTRB;

  // Local response channel
  logic                     RSP_VALID;
  logic                     RSP_READY;
  logic                     RSP_WRITE;
  logic [DATA_WIDTH-1:0]    RSP_RDATA;
  logic [1:0]               RSP_RESP;
  logic [ERR_CNT_WIDTH-1:0] ERR_COUNT;

  // AXI4-Lite
  logic                     M_AXI_AWVALID;
  logic                     M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR;
  logic [2:0]               M_AXI_AWPROT;
  logic                     M_AXI_WVALID;
  logic                     M_AXI_WREADY;
  logic [DATA_WIDTH-1:0]    M_AXI_WDATA;
  logic [STRB_WIDTH-1:0]    M_AXI_WSTRB;
  logic                     M_AXI_BVALID;
  logic                     M_AXI_BREADY;
  logic [1:0]               M_AXI_BRESP;
  logic                     M_AXI_ARVALID;
  logic                     M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR;
  logic [2:0]               M_AXI_ARPROT;
  logic                     M_AXI_RVALID;
  logic                     M_AXI_RREADY;
  logic [DATA_WIDTH-1:0]    M_AXI_RDATA;
  logic [1:0]               M_AXI_RRESP;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    output CMD_READY,
    output RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, ERR_COUNT,
    input  RSP_READY,
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_AWREADY,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WREADY,
    input  M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARREADY,
    input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    input  CMD_READY,
    input  RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, ERR_COUNT,
    output RSP_READY,
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_AWREADY,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WREADY,
    output M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARREADY,
    output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns local valid/ready commands into AW/W/B or AR/R
// transactions and returns registered responses plus a saturating error count.
module axi_4_lite_mst #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input logic              M_AXI_ACLK,
  input logic              M_AXI_ARESETN,
  axi_4_lite_mst_if.master bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } state_e;

  state_e                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]    awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]    araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;

  logic       aw_hs, w_hs;
  logic       cap_en;
  logic [1:0] cap_resp;

  assign aw_hs = awvalid_q & bus.M_AXI_AWREADY;
  assign w_hs  = wvalid_q & bus.M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_cnt_d   = err_cnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cap_en      = 1'b0;
    cap_resp    = 2'b00;

    case (state_q)
      StIdle: begin
        if (bus.CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (bus.CMD_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = bus.CMD_ADDR;
            wdata_d   = bus.CMD_WDATA;
            wstrb_d   = bus.CMD_WSTRB;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWrAddrData;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = bus.CMD_ADDR;
            state_d   = StRdAddr;
          end
        end
      end

      StWrAddrData: begin
        // AW and W complete independently; a slave may hold WREADY until AW is taken.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end

      StWrResp: begin
        if (bus.M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.M_AXI_BRESP;
          cap_en      = 1'b1;
          cap_resp    = bus.M_AXI_BRESP;
          state_d     = StResp;
        end
      end

      StRdAddr: begin
        if (arvalid_q && bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end

      StRdData: begin
        if (bus.M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = bus.M_AXI_RDATA;
          rsp_resp_d  = bus.M_AXI_RRESP;
          cap_en      = 1'b1;
          cap_resp    = bus.M_AXI_RRESP;
          state_d     = StResp;
        end
      end

      StResp: begin
        if (bus.RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (cap_en && (cap_resp != 2'b00) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_cnt_q   <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign bus.CMD_READY     = cmd_ready_q;
  assign bus.RSP_VALID     = rsp_valid_q;
  assign bus.RSP_WRITE     = rsp_write_q;
  assign bus.RSP_RDATA     = rsp_rdata_q;
  assign bus.RSP_RESP      = rsp_resp_q;
  assign bus.ERR_COUNT     = err_cnt_q;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_AWADDR  = awaddr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_ARADDR  = araddr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: delay-configurable AXI4-Lite slave, protocol monitor and a
// byte-lane memory model that predicts every response.
module tb_axi_4_lite_mst;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi_4_lite_mst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) bus ();

  axi_4_lite_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave knobs
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit         w_after_aw = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [31:0] smem [64] = '{default: '0};
  logic        aw_got, w_got, ar_got;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
  logic [3:0]  w_strb_s;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.M_AXI_AWREADY <= 1'b0;
      bus.M_AXI_WREADY  <= 1'b0;
      bus.M_AXI_BVALID  <= 1'b0;
      bus.M_AXI_BRESP   <= 2'b00;
      bus.M_AXI_ARREADY <= 1'b0;
      bus.M_AXI_RVALID  <= 1'b0;
      bus.M_AXI_RDATA   <= '0;
      bus.M_AXI_RRESP   <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; ar_addr_s <= '0;
    end else begin
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        bus.M_AXI_AWREADY <= 1'b0; aw_got <= 1'b1; aw_addr_s <= bus.M_AXI_AWADDR; aw_cnt <= 0;
      end else if (bus.M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt >= aw_dly) bus.M_AXI_AWREADY <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        bus.M_AXI_WREADY <= 1'b0; w_got <= 1'b1; w_cnt <= 0;
        w_data_s <= bus.M_AXI_WDATA; w_strb_s <= bus.M_AXI_WSTRB;
      end else if (bus.M_AXI_WVALID && !w_got && (!w_after_aw || aw_got)) begin
        if (w_cnt >= w_dly) bus.M_AXI_WREADY <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        bus.M_AXI_BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (aw_got && w_got && !bus.M_AXI_BVALID) begin
        if (b_cnt >= b_dly) begin
          bus.M_AXI_BVALID <= 1'b1;
          bus.M_AXI_BRESP  <= bresp_cfg;
          smem[aw_addr_s[7:2]] <= (smem[aw_addr_s[7:2]] & ~strb_mask(w_strb_s)) |
                                  (w_data_s & strb_mask(w_strb_s));
        end else b_cnt <= b_cnt + 1;
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        bus.M_AXI_ARREADY <= 1'b0; ar_got <= 1'b1; ar_addr_s <= bus.M_AXI_ARADDR; ar_cnt <= 0;
      end else if (bus.M_AXI_ARVALID && !ar_got) begin
        if (ar_cnt >= ar_dly) bus.M_AXI_ARREADY <= 1'b1;
        else ar_cnt <= ar_cnt + 1;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
        bus.M_AXI_RVALID <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end else if (ar_got && !bus.M_AXI_RVALID) begin
        if (r_cnt >= r_dly) begin
          bus.M_AXI_RVALID <= 1'b1;
          bus.M_AXI_RDATA  <= smem[ar_addr_s[7:2]];
          bus.M_AXI_RRESP  <= rresp_cfg;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Protocol monitor: VALID/payload hold, constant PROT, nothing in flight while CMD_READY
  int          viol = 0;
  int          rsp_hs_cnt = 0;
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
    end else begin
      viol <= viol
        + int'(p_aw && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr))
        + int'(p_w && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata ||
                       bus.M_AXI_WSTRB != p_wstrb))
        + int'(p_ar && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr))
        + int'(bus.M_AXI_AWPROT != 3'b000 || bus.M_AXI_ARPROT != 3'b000)
        + int'(bus.CMD_READY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_ARVALID ||
                                 bus.M_AXI_BREADY || bus.M_AXI_RREADY || bus.RSP_VALID));
      p_aw <= bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      p_w  <= bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      p_ar <= bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
      p_awaddr <= bus.M_AXI_AWADDR;
      p_wdata  <= bus.M_AXI_WDATA;
      p_wstrb  <= bus.M_AXI_WSTRB;
      p_araddr <= bus.M_AXI_ARADDR;
      if (bus.RSP_VALID && bus.RSP_READY) rsp_hs_cnt <= rsp_hs_cnt + 1;
    end
  end

  // Reference model
  logic [31:0] ref_mem [64] = '{default: '0};
  int          exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output bit acc);
    bit rdy;
    int cyc = 0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = data;
    bus.CMD_WSTRB = strb;
    rdy = bus.CMD_READY;
    while (!rdy && cyc < 50) begin
      @(posedge clk); #1;
      rdy = bus.CMD_READY;
      cyc++;
    end
    if (rdy) begin
      @(posedge clk); #1;
    end
    bus.CMD_VALID = 1'b0;
    acc = rdy;
    chk("cmd_accept", rdy, 1'b1);
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int hold, output logic [31:0] rd_o);
    logic [31:0] exp_rd, rd0;
    logic [1:0]  exp_resp, rs0;
    logic        wr0;
    int          hs0, cyc;
    bit          acc, seen, busy_bad, unstable;
    rd_o     = 'x;
    exp_resp = wr ? bresp_cfg : rresp_cfg;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (strb[i]) ref_mem[addr[7:2]][8*i +: 8] = data[8*i +: 8];
      exp_rd = '0;
    end else begin
      exp_rd = ref_mem[addr[7:2]];
    end
    if (exp_resp != 2'b00) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    hs0 = rsp_hs_cnt;
    bus.RSP_READY = (hold == 0);
    send_cmd(wr, addr, data, strb, acc);
    if (!acc) begin
      bus.RSP_READY = 1'b0;
      return;
    end
    chk("cmd_ready_drop", bus.CMD_READY, 1'b0);
    seen = 1'b0; busy_bad = 1'b0; cyc = 0;
    while (!seen && cyc < 400) begin
      if (bus.RSP_VALID) seen = 1'b1;
      else begin
        if (bus.CMD_READY) busy_bad = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("rsp_timeout", seen, 1'b1);
    if (!seen) begin
      bus.RSP_READY = 1'b0;
      return;
    end
    chk("rsp_write", bus.RSP_WRITE, wr);
    chk("rsp_rdata", bus.RSP_RDATA, exp_rd);
    chk("rsp_resp", bus.RSP_RESP, exp_resp);
    chk("err_count", bus.ERR_COUNT, exp_err);
    rd_o = bus.RSP_RDATA;
    rd0 = bus.RSP_RDATA; rs0 = bus.RSP_RESP; wr0 = bus.RSP_WRITE;
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== rd0 || bus.RSP_RESP !== rs0 ||
          bus.RSP_WRITE !== wr0 || bus.CMD_READY !== 1'b0) unstable = 1'b1;
    end
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
    chk("rsp_stable", unstable, 1'b0);
    chk("rsp_drop", bus.RSP_VALID, 1'b0);
    chk("cmd_ready_back", bus.CMD_READY, 1'b1);
    chk("busy_while_inflight", busy_bad, 1'b0);
    chk("one_rsp", rsp_hs_cnt - hs0, 1);
    chk("protocol", viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    bit          acc;
    int          hs0;

    bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0;
    bus.CMD_WDATA = '0;   bus.CMD_WSTRB = '0;   bus.RSP_READY = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.CMD_READY, 1'b1);
    chk("rst_rsp_valid", bus.RSP_VALID, 1'b0);
    chk("rst_rsp_write", bus.RSP_WRITE, 1'b0);
    chk("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    chk("rst_rsp_resp", bus.RSP_RESP, 2'b00);
    chk("rst_err_count", bus.ERR_COUNT, 8'h00);
    chk("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 3'b000);
    chk("rst_readys", {bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 2'b00);
    chk("rst_awaddr", bus.M_AXI_AWADDR, 32'h0);
    chk("rst_araddr", bus.M_AXI_ARADDR, 32'h0);
    chk("rst_wdata", bus.M_AXI_WDATA, 32'h0);
    chk("rst_wstrb", bus.M_AXI_WSTRB, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read and partial-strobe merge
    do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, rd);
    do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd);
    chk("read_back_0x4", rd, 32'hDEADBEEF);
    do_cmd(1'b1, 32'h8, 32'h11223344, 4'b0101, 1, rd);
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, rd);
    chk("read_back_0x8", rd, 32'h00220044);

    // W accepted well before AW, slow B
    aw_dly = 4; w_dly = 1; b_dly = 5;
    do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 2, rd);
    // Slave that only raises WREADY after AW is taken
    aw_dly = 2; w_dly = 0; b_dly = 0; w_after_aw = 1'b1;
    do_cmd(1'b1, 32'h14, 32'h0BADC0DE, 4'b1100, 0, rd);
    w_after_aw = 1'b0; aw_dly = 0;
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 0, rd);

    // Randomized mix with occasional error responses
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      w_after_aw = 1'($urandom_range(0, 1));
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      a = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      d = $urandom;
      do_cmd(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), rd);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; w_after_aw = 1'b0;
    bresp_cfg = 2'b00;

    // Error-count saturation
    rresp_cfg = 2'b10;
    for (int i = 0; i < 300; i++) begin
      a = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      do_cmd(1'b0, a, 32'h0, 4'h0, (i == 0) ? 4 : 0, rd);
    end
    chk("err_saturated", bus.ERR_COUNT, 8'hFF);
    rresp_cfg = 2'b00;

    // Reset while ARVALID is pending
    ar_dly = 10;
    hs0 = rsp_hs_cnt;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arvalid_pending", bus.M_AXI_ARVALID, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_arvalid", bus.M_AXI_ARVALID, 1'b0);
    chk("rst_async_rsp_valid", bus.RSP_VALID, 1'b0);
    chk("rst_async_err", bus.ERR_COUNT, 8'h00);
    exp_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", bus.CMD_READY, 1'b1);
    chk("post_rst_no_rsp", rsp_hs_cnt - hs0, 0);
    ar_dly = 0;
    do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd);
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 1, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
